// File: rtl/branch_flag_unit.sv
// Execute-stage flag latch and branch resolver: registers N/Z/C/V from ALU results,
// resolves branches against the registered flags and drives the PC redirect and wrong-path flush.
module branch_flag_unit #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] result,
    input  logic        carry_in,
    input  logic        ovf_in,
    input  logic        flag_we,
    input  logic        is_branch,
    input  logic [2:0]  cond,
    input  logic [31:0] target,
    output logic [3:0]  flags,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        flush
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned FLAG_W = 4;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic {
        IDLE     = 1'b0,
        FLUSHING = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [FLAG_W-1:0]   flags_q, flags_d;
    logic                redirect_q, redirect_d;
    logic [DATA_W-1:0]   redirect_pc_q, redirect_pc_d;
    logic                flush_q, flush_d;
    logic                ready_q;

    logic                accept_c;
    logic                any_set_c;
    logic [FLAG_W-1:0]   new_flags_c;
    logic                cond_true_c;
    logic                taken_c;

    assign accept_c = in_valid && ready_q;

    // 32-input OR zero detect feeding Z
    assign any_set_c   = |result;
    assign new_flags_c = {result[DATA_W-1], ~any_set_c, carry_in, ovf_in};

    // Conditions look at the registered flags only; flags_q = {N,Z,C,V}
    always_comb begin
        cond_true_c = 1'b0;
        case (cond)
            3'b000:  cond_true_c = 1'b1;
            3'b001:  cond_true_c = flags_q[2];
            3'b010:  cond_true_c = ~flags_q[2];
            3'b011:  cond_true_c = ~flags_q[3];
            3'b100:  cond_true_c = flags_q[3];
            3'b101:  cond_true_c = flags_q[1];
            3'b110:  cond_true_c = ~flags_q[1];
            default: cond_true_c = flags_q[0];
        endcase
    end

    assign taken_c = accept_c && is_branch && cond_true_c;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: the counter holds the flush cycles still to come after the current one
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (taken_c) begin
                    state_d = FLUSHING;
                    cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
                end
            end
            default: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
        endcase
    end

    // Next output values; transactions seen while flushing are wrong-path and dropped
    always_comb begin
        flags_d       = flags_q;
        redirect_d    = 1'b0;
        redirect_pc_d = redirect_pc_q;
        flush_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_c && flag_we) begin
                    flags_d = new_flags_c;
                end
                if (taken_c) begin
                    redirect_d    = 1'b1;
                    redirect_pc_d = target;
                    flush_d       = 1'b1;
                end
            end
            default: begin
                flush_d = (cnt_q != '0);
            end
        endcase
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q       <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            flush_q       <= 1'b0;
            ready_q       <= 1'b0;
        end else begin
            flags_q       <= flags_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            flush_q       <= flush_d;
            ready_q       <= 1'b1;
        end
    end

    assign in_ready    = ready_q;
    assign flags       = flags_q;
    assign redirect    = redirect_q;
    assign redirect_pc = redirect_pc_q;
    assign flush       = flush_q;

endmodule

// File: tb/tb_branch_flag_unit.sv
// Directed bench for branch_flag_unit: a transaction-level model checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_branch_flag_unit;

    localparam int unsigned FC = 2;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] result;
    logic        carry_in;
    logic        ovf_in;
    logic        flag_we;
    logic        is_branch;
    logic [2:0]  cond;
    logic [31:0] target;
    logic [3:0]  flags;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flush;

    int total = 0;
    int bad   = 0;

    branch_flag_unit #(.FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .result(result), .carry_in(carry_in), .ovf_in(ovf_in), .flag_we(flag_we),
        .is_branch(is_branch), .cond(cond), .target(target), .flags(flags),
        .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: flags as {N,Z,C,V}; flush_left counts remaining flush cycles including the current one
    logic [3:0]  m_flags;
    logic        m_redir;
    logic [31:0] m_pc;
    int          m_flush_left;
    logic        m_ready;

    function automatic logic cond_holds(input logic [3:0] f, input logic [2:0] c);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            3'd0: return 1'b1;
            3'd1: return z;
            3'd2: return !z;
            3'd3: return !n;
            3'd4: return n;
            3'd5: return cy;
            3'd6: return !cy;
            default: return v;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_flags = 4'h0; m_redir = 1'b0; m_pc = 32'h0; m_flush_left = 0; m_ready = 1'b0;
        end else begin
            logic take;
            m_redir = 1'b0;
            if (m_flush_left > 0) begin
                m_flush_left = m_flush_left - 1;
            end else if (in_valid && m_ready) begin
                take = is_branch && cond_holds(m_flags, cond);
                if (flag_we) m_flags = {result[31], result == 32'h0, carry_in, ovf_in};
                if (take) begin
                    m_redir = 1'b1;
                    m_pc = target;
                    m_flush_left = FC;
                end
            end
            m_ready = 1'b1;
        end
    end

    // Per-cycle comparison against the model, mid-cycle
    always @(negedge clk) begin
        if (rst_n) begin
            chk("flags",       32'(flags),       32'(m_flags));
            chk("redirect",    32'(redirect),    32'(m_redir));
            chk("redirect_pc", redirect_pc,      m_pc);
            chk("flush",       32'(flush),       32'(m_flush_left > 0));
            chk("in_ready",    32'(in_ready),    32'(m_ready));
        end
    end

    // Present one transaction, then advance to 1 time unit after the capturing edge
    task automatic cyc(input logic v, input logic [31:0] res, input logic c, input logic o,
                       input logic we, input logic br, input logic [2:0] cd, input logic [31:0] tgt);
        in_valid = v; result = res; carry_in = c; ovf_in = o;
        flag_we = we; is_branch = br; cond = cd; target = tgt;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0);
    endtask

    task automatic wr(input logic [31:0] res, input logic c, input logic o);
        cyc(1'b1, res, c, o, 1'b1, 1'b0, 3'd0, 32'h0);
    endtask

    task automatic br(input logic [2:0] cd, input logic [31:0] tgt);
        cyc(1'b1, 32'h1, 1'b0, 1'b0, 1'b0, 1'b1, cd, tgt);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; result = '0; carry_in = 1'b0; ovf_in = 1'b0;
        flag_we = 1'b0; is_branch = 1'b0; cond = '0; target = '0;
        #1;
        chk("rst_flags", 32'(flags), 32'h0);
        chk("rst_ready", 32'(in_ready), 32'h0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // 1: idle after reset
        idle();
        chk("t1_ready", 32'(in_ready), 32'h1);
        chk("t1_flush", 32'(flush), 32'h0);

        // 2: flag loads
        wr(32'h0, 1'b0, 1'b0);
        chk("t2_zero", 32'(flags), 32'h4);
        wr(32'h8000_0000, 1'b1, 1'b0);
        chk("t2_neg_carry", 32'(flags), 32'hA);

        // 3: taken BZ, wrong-path writes dropped during the flush
        wr(32'h0, 1'b0, 1'b0);
        br(3'd1, 32'h40);
        chk("t3_redirect", 32'(redirect), 32'h1);
        chk("t3_pc", redirect_pc, 32'h40);
        chk("t3_flush0", 32'(flush), 32'h1);
        wr(32'h5, 1'b0, 1'b0);
        chk("t3_redirect_drop", 32'(redirect), 32'h0);
        chk("t3_flush1", 32'(flush), 32'h1);
        wr(32'h5, 1'b0, 1'b0);
        chk("t3_flush_end", 32'(flush), 32'h0);
        chk("t3_flags_kept", 32'(flags), 32'h4);
        idle();
        chk("t3_pc_hold", redirect_pc, 32'h40);

        // 4: not-taken BNZ, then a flag write
        br(3'd2, 32'h99);
        chk("t4_no_redirect", 32'(redirect), 32'h0);
        chk("t4_no_flush", 32'(flush), 32'h0);
        wr(32'h7, 1'b0, 1'b0);
        chk("t4_flags", 32'(flags), 32'h0);

        // 5: back-to-back write then branch; combined branch+write uses old flags
        wr(32'h0, 1'b0, 1'b0);
        br(3'd1, 32'h80);
        chk("t5_b2b_taken", 32'(redirect), 32'h1);
        idle(); idle();
        wr(32'h7, 1'b0, 1'b0);
        cyc(1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 32'h100);
        chk("t5_combo_not_taken", 32'(redirect), 32'h0);
        chk("t5_combo_flags", 32'(flags), 32'h4);

        // V and N conditions
        wr(32'h8000_0000, 1'b0, 1'b1);
        chk("t5_nv_flags", 32'(flags), 32'h9);
        br(3'd7, 32'h200);
        chk("t5_bvs", redirect_pc, 32'h200);
        idle(); idle();
        br(3'd3, 32'h300);
        chk("t5_bpl_not_taken", 32'(redirect), 32'h0);
        br(3'd6, 32'h304);
        chk("t5_bcc_taken", 32'(redirect), 32'h1);
        idle(); idle();

        // 6: asynchronous reset in the middle of a flush
        wr(32'h8000_0000, 1'b1, 1'b0);
        br(3'd0, 32'hC0);
        chk("t6_redirect", 32'(redirect), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_flush", 32'(flush), 32'h0);
        chk("t6_async_redirect", 32'(redirect), 32'h0);
        chk("t6_async_flags", 32'(flags), 32'h0);
        chk("t6_async_pc", redirect_pc, 32'h0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        idle();
        chk("t6_flags_after", 32'(flags), 32'h0);
        br(3'd0, 32'h44);
        chk("t6_redirect_after", 32'(redirect), 32'h1);
        chk("t6_pc_after", redirect_pc, 32'h44);
        idle(); idle(); idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
